// File: rtl/stream_demux_1ton_pkg.sv
// +------------------------------------------------------------------+
// | demux_pkg - shared width helper and error counter width          |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

package demux_pkg;

  localparam int ERR_CNT_W = 16;

  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/stream_demux_1ton_if.sv
// +------------------------------------------------------------------+
// | stream_demux_1ton_if - producer/consumer bundle of the 1:N demux |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

interface stream_demux_1ton_if
  import demux_pkg::*;
#(
  parameter int N     = 4,
  parameter int W     = 8,
  parameter int SEL_W = sel_width(N)
);

  logic                 in_valid;
  logic                 in_ready;
  logic [W-1:0]         in_data;
  logic [SEL_W-1:0]     in_sel;
  logic [N-1:0]         out_valid;
  logic [N-1:0]         out_ready;
  logic [N*W-1:0]       out_data;
  logic [ERR_CNT_W-1:0] err_cnt;

  modport master (
    output in_valid, in_data, in_sel, out_ready,
    input  in_ready, out_valid, out_data, err_cnt
  );

  modport slave (
    input  in_valid, in_data, in_sel, out_ready,
    output in_ready, out_valid, out_data, err_cnt
  );

endinterface

`default_nettype wire

// File: rtl/stream_demux_1ton_out_reg.sv
// +------------------------------------------------------------------+
// | demux_out_reg - one-entry channel register with valid/ready      |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module demux_out_reg #(
  parameter int W = 8
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  input  wire logic         load,
  input  wire logic [W-1:0] din,
  input  wire logic         ready,
  output logic              valid,
  output logic [W-1:0]      dout
);

  // A load is only issued when the slot is empty or draining, so load wins.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid <= 1'b0;
      dout  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      dout  <= din;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/stream_demux_1ton.sv
// +------------------------------------------------------------------+
// | stream_demux_1ton - registered 1:N stream demux, per-channel     |
// | backpressure; DEMUX_ERR_CNT_EN enables the dropped-word counter  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module stream_demux_1ton
  import demux_pkg::*;
#(
  parameter int N = 4,
  parameter int W = 8
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  stream_demux_1ton_if.slave bus
);

  logic         sel_ok;
  logic [N-1:0] hit;
  logic [N-1:0] load;
  logic         accept;

  generate
    if (N > 1) begin : g_range
      assign sel_ok = (int'(bus.in_sel) < N);
    end else begin : g_single
      assign sel_ok = 1'b1;
    end
  endgenerate

  always_comb begin
    hit = '0;
    for (int k = 0; k < N; k++) begin
      hit[k] = sel_ok && ((N == 1) || (int'(bus.in_sel) == k));
    end
  end

  // Only the addressed channel gates the producer; out-of-range words always pass.
  assign bus.in_ready = !sel_ok || (|(hit & (~bus.out_valid | bus.out_ready)));
  assign accept       = bus.in_valid && bus.in_ready;
  assign load         = accept ? hit : '0;

  generate
    for (genvar k = 0; k < N; k++) begin : g_chan
      demux_out_reg #(.W(W)) u_out_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load[k]),
        .din   (bus.in_data),
        .ready (bus.out_ready[k]),
        .valid (bus.out_valid[k]),
        .dout  (bus.out_data[k*W +: W])
      );
    end
  endgenerate

`ifdef DEMUX_ERR_CNT_EN
  logic [ERR_CNT_W-1:0] err_count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_count <= '0;
    end else if (accept && !sel_ok && (err_count != {ERR_CNT_W{1'b1}})) begin
      err_count <= err_count + 1'b1;
    end
  end

  assign bus.err_cnt = err_count;
`else
  assign bus.err_cnt = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_stream_demux_1ton.sv
// +------------------------------------------------------------------+
// | tb_stream_demux_1ton - bench for stream_demux_1ton (N=4 and N=3) |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module tb_stream_demux_1ton;
  import demux_pkg::*;

`ifdef DEMUX_ERR_CNT_EN
  localparam int ERR_ON = 1;
`else
  localparam int ERR_ON = 0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  stream_demux_1ton_if #(.N(4), .W(8)) bus4 ();
  stream_demux_1ton_if #(.N(3), .W(8)) bus3 ();

  stream_demux_1ton #(.N(4), .W(8)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4.slave));
  stream_demux_1ton #(.N(3), .W(8)) dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3.slave));

  int n_checks = 0;
  int n_errors = 0;

  // Reference: each channel is a queue of pending words, head is what the consumer sees.
  logic [7:0] mq [4][$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < 4; k++) mq[k].delete();
  endtask

  task automatic check_outs();
    logic [3:0] ev;
    for (int k = 0; k < 4; k++) ev[k] = (mq[k].size() != 0);
    chk("out_valid", 32'(bus4.out_valid), 32'(ev));
    for (int k = 0; k < 4; k++)
      if (mq[k].size() != 0) chk("out_data", 32'(bus4.out_data[k*8 +: 8]), 32'(mq[k][0]));
  endtask

  task automatic cycle(input logic v, input logic [1:0] s, input logic [7:0] d,
                       input logic [3:0] ordy, output logic rdy);
    logic er;
    bus4.in_valid  = v;
    bus4.in_sel    = s;
    bus4.in_data   = d;
    bus4.out_ready = ordy;
    #1;
    rdy = bus4.in_ready;
    er  = (mq[s].size() == 0) || ordy[s];
    chk("in_ready", 32'(rdy), 32'(er));
    @(posedge clk);
    for (int k = 0; k < 4; k++)
      if (ordy[k] && mq[k].size() != 0) void'(mq[k].pop_front());
    if (v && er) mq[s].push_back(d);
    @(negedge clk);
    check_outs();
  endtask

  initial begin
    logic rdy;

    rst_n          = 1'b0;
    bus4.in_valid  = 1'b1;
    bus4.in_sel    = 2'd2;
    bus4.in_data   = 8'hFF;
    bus4.out_ready = 4'hF;
    bus3.in_valid  = 1'b0;
    bus3.in_sel    = 2'd0;
    bus3.in_data   = 8'h00;
    bus3.out_ready = 3'b111;

    // Reset held with a word offered
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 32'(bus4.out_valid), 32'h0);
    chk("rst_out_data", bus4.out_data, 32'h0);
    chk("rst_err_cnt", 32'(bus4.err_cnt), 32'h0);
    chk("rst3_out_valid", 32'(bus3.out_valid), 32'h0);
    chk("rst3_err_cnt", 32'(bus3.err_cnt), 32'h0);
    model_clear();
    rst_n = 1'b1;

    cycle(1'b1, 2'd2, 8'hA5, 4'hF, rdy);
    chk("first_valid", 32'(bus4.out_valid), 32'h4);
    chk("first_data", 32'(bus4.out_data[23:16]), 32'hA5);

    // Backpressure on channel 1
    cycle(1'b1, 2'd1, 8'h11, 4'b1101, rdy);
    cycle(1'b1, 2'd1, 8'h22, 4'b1101, rdy);
    chk("bp_stall_ready", 32'(rdy), 32'h0);
    cycle(1'b1, 2'd3, 8'h33, 4'b1101, rdy);
    chk("bp_other_ready", 32'(rdy), 32'h1);
    chk("bp_hold_data", 32'(bus4.out_data[15:8]), 32'h11);
    cycle(1'b1, 2'd1, 8'h22, 4'b1111, rdy);
    chk("bp_release_ready", 32'(rdy), 32'h1);
    chk("bp_release_data", 32'(bus4.out_data[15:8]), 32'h22);

    // Streaming round-robin at full rate
    for (int i = 0; i < 16; i++) begin
      cycle(1'b1, 2'(i % 4), 8'(i), 4'hF, rdy);
      chk("stream_ready", 32'(rdy), 32'h1);
      chk("stream_data", 32'(bus4.out_data[(i % 4)*8 +: 8]), 32'(i));
    end
    cycle(1'b0, 2'd0, 8'h00, 4'hF, rdy);

    // Same-cycle drain and load
    cycle(1'b1, 2'd0, 8'h5A, 4'hF, rdy);
    cycle(1'b1, 2'd0, 8'hC3, 4'hF, rdy);
    chk("dl_valid0", 32'(bus4.out_valid[0]), 32'h1);
    chk("dl_data0", 32'(bus4.out_data[7:0]), 32'hC3);
    cycle(1'b0, 2'd0, 8'h00, 4'hF, rdy);

    // Reset while channels 0 and 2 are stalled
    cycle(1'b1, 2'd0, 8'h01, 4'b1010, rdy);
    cycle(1'b1, 2'd2, 8'h02, 4'b1010, rdy);
    chk("mid_pre_valid", 32'(bus4.out_valid), 32'h5);
    bus4.in_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    chk("mid_rst_valid", 32'(bus4.out_valid), 32'h0);
    cycle(1'b1, 2'd2, 8'h77, 4'hF, rdy);
    chk("mid_after_valid", 32'(bus4.out_valid), 32'h4);
    chk("mid_after_data", 32'(bus4.out_data[23:16]), 32'h77);

    // Out-of-range words on the 3-channel instance
    bus3.in_valid  = 1'b1;
    bus3.in_sel    = 2'd3;
    bus3.out_ready = 3'b000;
    for (int i = 0; i < 5; i++) begin
      bus3.in_data = 8'(8'h40 + i);
      #1;
      chk("oor_ready", 32'(bus3.in_ready), 32'h1);
      @(posedge clk);
      @(negedge clk);
      chk("oor_no_valid", 32'(bus3.out_valid), 32'h0);
    end
    chk("oor_err_cnt", 32'(bus3.err_cnt), 32'(ERR_ON * 5));
`ifdef DEMUX_ERR_CNT_EN
    repeat (65535) @(posedge clk);
    @(negedge clk);
    chk("oor_err_sat", 32'(bus3.err_cnt), 32'hFFFF);
`endif
    bus3.in_sel = 2'd1;
    bus3.in_data = 8'h9C;
    @(posedge clk);
    @(negedge clk);
    bus3.in_valid = 1'b0;
    chk("n3_inrange_valid", 32'(bus3.out_valid), 32'h2);
    chk("n3_inrange_data", 32'(bus3.out_data[15:8]), 32'h9C);

    // Random traffic against the queue model
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 8'($urandom),
            4'($urandom), rdy);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
